mux7seg_timer: RTL and testbench

Parametrised successor to the irrigation-panel elapsed-time counter and 7-segment multiplexer. Counts valve-open time in NUM_DIGITS BCD digits, either mm:ss-style or pure decimal. Scans the digits onto one shared segment bus with leading-zero blanking, a display freeze and saturation/overflow reporting. Sits in the irrigation top level: `run` comes from the valve output, and `seg`/`dig_en` drive the board display directly.

---
 rtl/mux7seg_pkg.sv | 21 ++
 rtl/seg7_bcd_decoder.sv | 20 ++
 rtl/mux7seg_timer.sv | 148 ++++++++++++++
 tb/tb_mux7seg_timer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux7seg_pkg.sv
// rtl/mux7seg_pkg.sv - shared constants and helpers for the 7-segment elapsed-time display
package mux7seg_pkg;

  // Active-high segment patterns, bit 6 = a ... bit 0 = g
  localparam logic [6:0] SEG_OFF = 7'b0000000;
  localparam logic [6:0] SEG_PATTERN [0:9] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };

  // Time mode alternates seconds/minutes tens digits (radix 6) on digits 1 and 3
  function automatic logic [3:0] digit_radix(input int index, input bit time_mode);
    if (time_mode && index < 4 && index[0]) return 4'd6;
    return 4'd10;
  endfunction

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_bcd_decoder.sv
// rtl/seg7_bcd_decoder.sv - BCD digit to 7-segment pattern with blanking and polarity
module seg7_bcd_decoder
  import mux7seg_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] value,
  input  logic       blank,
  output logic [6:0] seg
);

  logic [6:0] pattern;

  always_comb begin
    pattern = SEG_OFF;
    if (!blank && value <= 4'd9) pattern = SEG_PATTERN[value];
    seg = ACTIVE_LOW ? ~pattern : pattern;
  end

endmodule

// File: rtl/mux7seg_timer.sv
// rtl/mux7seg_timer.sv - BCD elapsed-time counter with multiplexed 7-segment scan output
module mux7seg_timer
  import mux7seg_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int TICK_HZ        = 1,
  parameter int SCAN_HZ        = 1000,
  parameter int NUM_DIGITS     = 4,
  parameter bit TIME_MODE      = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b0,
  parameter bit BLANK_LEADING  = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    run,
  input  logic                    clear,
  input  logic                    freeze,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic [4*NUM_DIGITS-1:0] count_bcd,
  output logic                    tick,
  output logic                    overflow
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int SCAN_DIV = CLK_HZ / (SCAN_HZ * NUM_DIGITS);
  localparam int PW       = cnt_width(TICK_DIV);
  localparam int SW       = cnt_width(SCAN_DIV);
  localparam int IW       = cnt_width(NUM_DIGITS);

  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [6:0]    SEG_ZERO  = SEG_ACTIVE_LOW ? ~SEG_PATTERN[0] : SEG_PATTERN[0];

  logic [PW-1:0]           pre;
  logic                    tick_event;
  logic [4*NUM_DIGITS-1:0] count_next;
  logic                    all_max;
  logic [4*NUM_DIGITS-1:0] snap;
  logic [SW-1:0]           scan_cnt;
  logic [IW-1:0]           scan_idx;
  logic [NUM_DIGITS-1:0]   blank_vec;
  logic [3:0]              cur_digit;
  logic                    cur_blank;
  logic [6:0]              seg_d;
  logic [NUM_DIGITS-1:0]   dig_d;

  assign tick_event = run && (pre == PRE_LAST);

  // Ripple increment across mixed-radix digits, all resolved in one cycle
  always_comb begin
    logic carry;
    count_next = count_bcd;
    all_max    = 1'b1;
    carry      = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (count_bcd[4*i +: 4] != digit_radix(i, TIME_MODE) - 4'd1) all_max = 1'b0;
      if (carry) begin
        if (count_bcd[4*i +: 4] == digit_radix(i, TIME_MODE) - 4'd1) begin
          count_next[4*i +: 4] = 4'd0;
        end else begin
          count_next[4*i +: 4] = count_bcd[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      pre       <= '0;
      count_bcd <= '0;
      overflow  <= 1'b0;
      tick      <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (run) pre <= (pre == PRE_LAST) ? '0 : pre + PW'(1);
      if (tick_event && !overflow) begin
        if (all_max) begin
          overflow <= 1'b1;
        end else begin
          count_bcd <= count_next;
          tick      <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)       snap <= '0;
    else if (!freeze) snap <= count_bcd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IW'(1);
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  // A digit is blanked when it and every more-significant digit are zero
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    blank_vec  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero   = upper_zero && (snap[4*i +: 4] == 4'd0);
      blank_vec[i] = BLANK_LEADING && (i != 0) && upper_zero;
    end
  end

  always_comb begin
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    dig_d     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dig_d[i] = (scan_idx == IW'(i)) ^ DIG_ACTIVE_LOW;
      if (scan_idx == IW'(i)) begin
        cur_digit = snap[4*i +: 4];
        cur_blank = blank_vec[i];
      end
    end
  end

  seg7_bcd_decoder #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_decoder (
    .value(cur_digit),
    .blank(cur_blank),
    .seg  (seg_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      seg    <= SEG_ZERO;
      dig_en <= {NUM_DIGITS{DIG_ACTIVE_LOW}} ^ NUM_DIGITS'(1);
    end else begin
      seg    <= seg_d;
      dig_en <= dig_d;
    end
  end

endmodule

// File: tb/tb_mux7seg_timer.sv
// tb/tb_mux7seg_timer.sv - directed scoreboard bench for mux7seg_timer
module tb_mux7seg_timer;

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S7 = 7'b0001111;
  localparam logic [6:0] SB = 7'b1111111;

  logic clk = 1'b0;
  logic reset = 1'b1, run = 1'b0, clear = 1'b0, freeze = 1'b0;
  logic reset2 = 1'b1, run2 = 1'b0, clear2 = 1'b0, freeze2 = 1'b0;

  logic [6:0]  seg, seg2, seg3;
  logic [3:0]  dig_en, dig_en3;
  logic [1:0]  dig_en2;
  logic [15:0] count_bcd, count3;
  logic [7:0]  count2;
  logic        tick, tick2, tick3, overflow, overflow2, overflow3;

  int tick_cnt = 0, tick2_cnt = 0;
  int passed = 0, total = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mux7seg_timer #(.CLK_HZ(100), .TICK_HZ(10), .SCAN_HZ(5), .NUM_DIGITS(4)) dut (
    .clk(clk), .reset(reset), .run(run), .clear(clear), .freeze(freeze),
    .seg(seg), .dig_en(dig_en), .count_bcd(count_bcd), .tick(tick), .overflow(overflow)
  );

  mux7seg_timer #(.CLK_HZ(100), .TICK_HZ(10), .SCAN_HZ(5), .NUM_DIGITS(2)) dut2 (
    .clk(clk), .reset(reset2), .run(run2), .clear(clear2), .freeze(freeze2),
    .seg(seg2), .dig_en(dig_en2), .count_bcd(count2), .tick(tick2), .overflow(overflow2)
  );

  mux7seg_timer #(.CLK_HZ(100), .TICK_HZ(10), .SCAN_HZ(5), .NUM_DIGITS(4),
                  .BLANK_LEADING(1'b0)) dut3 (
    .clk(clk), .reset(reset), .run(run), .clear(clear), .freeze(freeze),
    .seg(seg3), .dig_en(dig_en3), .count_bcd(count3), .tick(tick3), .overflow(overflow3)
  );

  task automatic push_exp(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    total++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s: observed=%h expected=<none queued>", tag, obs);
      return;
    end
    e = exp_q.pop_front();
    assert (obs === e) passed++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      if (tick) tick_cnt++;
      if (tick2) tick2_cnt++;
    end
  endtask

  task automatic wait_dig(input string tag, input logic [3:0] target, input logic [3:0] prev_target);
    logic [3:0] prev;
    int n;
    prev = dig_en;
    n = 0;
    step(1);
    while (!(dig_en == target && prev == prev_target) && n < 100) begin
      prev = dig_en;
      step(1);
      n++;
    end
    push_exp(32'd1);
    check(tag, 32'(n < 100));
  endtask

  task automatic check_frame(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                             input logic [6:0] e2, input logic [6:0] e3);
    for (int c = 0; c < 20; c++) begin
      step(1);
      push_exp(32'd1);
      check({tag, "_onehot"}, 32'($onehot(dig_en)));
      case (dig_en)
        4'b0001: push_exp(32'(e0));
        4'b0010: push_exp(32'(e1));
        4'b0100: push_exp(32'(e2));
        default: push_exp(32'(e3));
      endcase
      check({tag, "_seg"}, 32'(seg));
    end
  endtask

  initial begin
    int t0;
    logic [6:0] e_blank, e_noblank;

    // Reset state
    step(2);
    push_exp(32'h0); check("rst_count", 32'(count_bcd));
    push_exp(32'h0); check("rst_tick", 32'(tick));
    push_exp(32'h0); check("rst_overflow", 32'(overflow));
    push_exp(32'h1); check("rst_dig_en", 32'(dig_en));
    push_exp(32'(S0)); check("rst_seg", 32'(seg));
    push_exp(32'h1); check("rst_dig_en2", 32'(dig_en2));
    reset = 1'b0;
    reset2 = 1'b0;

    // 1. Continuous run through the seconds-tens rollover
    run = 1'b1;
    t0 = tick_cnt;
    push_exp(32'h0059);
    step(590);
    check("run590_count", 32'(count_bcd));
    push_exp(32'h0100);
    push_exp(32'd60);
    step(10);
    check("run600_count", 32'(count_bcd));
    check("run600_ticks", 32'(tick_cnt - t0));
    run = 1'b0;

    // 2. Partial prescaler period survives a stopped valve
    clear = 1'b1;
    push_exp(32'h0);
    step(1);
    clear = 1'b0;
    check("clear_count", 32'(count_bcd));
    run = 1'b1;
    step(6);
    run = 1'b0;
    step(50);
    run = 1'b1;
    push_exp(32'h0);
    step(3);
    check("partial_3_count", 32'(count_bcd));
    push_exp(32'h1);
    push_exp(32'h1);
    step(1);
    check("partial_4_count", 32'(count_bcd));
    check("partial_4_tick", 32'(tick));
    run = 1'b0;

    // 3. Saturation on the two-digit instance
    run2 = 1'b1;
    t0 = tick2_cnt;
    push_exp(32'h59);
    push_exp(32'd59);
    step(590);
    check("sat_59_count", 32'(count2));
    check("sat_59_ticks", 32'(tick2_cnt - t0));
    push_exp(32'h59);
    push_exp(32'h1);
    push_exp(32'd59);
    step(10);
    check("sat_hold_count", 32'(count2));
    check("sat_overflow", 32'(overflow2));
    check("sat_no_tick", 32'(tick2_cnt - t0));
    step(9);
    clear2 = 1'b1;
    push_exp(32'h0);
    push_exp(32'h0);
    push_exp(32'h0);
    step(1);
    clear2 = 1'b0;
    run2 = 1'b0;
    check("sat_clear_count", 32'(count2));
    check("sat_clear_overflow", 32'(overflow2));
    check("sat_clear_tick", 32'(tick2));

    // 4. Scan order, slot length and leading-zero blanking at 0007
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    run = 1'b1;
    push_exp(32'h0007);
    step(70);
    run = 1'b0;
    check("scan_count", 32'(count_bcd));
    wait_dig("scan_sync", 4'b0001, 4'b1000);
    for (int d = 0; d < 4; d++) begin
      e_blank   = (d == 0) ? S7 : SB;
      e_noblank = (d == 0) ? S7 : S0;
      for (int c = 0; c < 5; c++) begin
        push_exp(32'(4'b0001 << d));
        check("scan_dig_en", 32'(dig_en));
        push_exp(32'(e_blank));
        check("scan_seg_blank", 32'(seg));
        push_exp(32'(4'b0001 << d));
        check("scan_dig_en_nb", 32'(dig_en3));
        push_exp(32'(e_noblank));
        check("scan_seg_noblank", 32'(seg3));
        step(1);
      end
    end

    // 5. Freeze holds the display while counting continues
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    run = 1'b1;
    step(30);
    run = 1'b0;
    step(1);
    freeze = 1'b1;
    run = 1'b1;
    push_exp(32'h0023);
    step(200);
    run = 1'b0;
    check("freeze_count", 32'(count_bcd));
    check_frame("freeze_disp", S3, SB, SB, SB);
    freeze = 1'b0;
    step(6);
    check_frame("release_disp", S3, S2, SB, SB);

    // 6. Reset mid-scan with one instance at 0042 and the other saturated
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    run = 1'b1;
    run2 = 1'b1;
    step(420);
    run = 1'b0;
    step(180);
    run2 = 1'b0;
    push_exp(32'h0042); check("pre_rst_count", 32'(count_bcd));
    push_exp(32'h1);    check("pre_rst_overflow2", 32'(overflow2));
    wait_dig("mid_scan_sync", 4'b0100, 4'b0010);
    reset = 1'b1;
    reset2 = 1'b1;
    step(1);
    reset = 1'b0;
    reset2 = 1'b0;
    push_exp(32'h0);    check("mid_rst_count", 32'(count_bcd));
    push_exp(32'h0);    check("mid_rst_tick", 32'(tick));
    push_exp(32'h1);    check("mid_rst_dig_en", 32'(dig_en));
    push_exp(32'(S0));  check("mid_rst_seg", 32'(seg));
    push_exp(32'h0);    check("mid_rst_count2", 32'(count2));
    push_exp(32'h0);    check("mid_rst_overflow2", 32'(overflow2));
    push_exp(32'h1);    check("mid_rst_dig_en2", 32'(dig_en2));
    push_exp(32'(S0));  check("mid_rst_seg2", 32'(seg2));
    step(1);
    push_exp(32'(S0));  check("post_rst_seg", 32'(seg));
    push_exp(32'h1);    check("post_rst_dig_en", 32'(dig_en));

    push_exp(32'h0);
    check("queue_drained", 32'(exp_q.size() - 1));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
